// File: rtl/pkt_reasm.sv
// pkt_reasm: receive-side flit decoder and per-VC packet reassembler.
//
// Each virtual channel has its own framing FSM and payload FIFO. Entries
// carry an end-of-packet flag. The consumer reads the FIFO head of the VC
// selected by rd_vc_i.
//
// Build option: define RAVENOC_PKT_LEN_CHECK_EN to enable the head-flit
// pkt_sz field, the per-VC remaining counter and len_err_o. When it is
// undefined, framing uses only the flit type: every packet is HEAD..TAIL,
// and len_err_o stays 0.
//
// Ports (top):
//   clk_noc, arst_noc      clock, asynchronous active-low reset
//   flit_valid_i/_data_i/_vc_i, flit_ready_o   flit input handshake
//   rd_vc_i, rd_ready_i    VC select and pop request
//   rd_valid_o/_data_o/_last_o                 head entry of the selected VC
//   pkt_avail_o            per-VC complete-packet count, VC0 in the low bits
//   seq_err_o, len_err_o   one-cycle error pulses
//   err_vc_o               VC of the latest error, held between errors

// Per-VC slice: framing FSM, payload FIFO and complete-packet counter.
//   acc      flit accepted for this VC (valid & ready & VC match)
//   ftype    flit type; payload is the flit payload
//   pop      consumer pops this VC (ignored when empty)
//   ready    this VC can take the flit currently presented
//   seq_e / len_e   the presented flit is a framing or length error
module pkt_reasm_vc #(
  parameter int DataW    = 32,
  parameter int Depth    = 4,
  parameter int PktWidth = 8,
  parameter int PktSzLsb = 16,
  localparam int CntW    = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic [1:0]       ftype,
  input  logic [DataW-1:0] payload,
  input  logic             pop,
  output logic             ready,
  output logic             seq_e,
  output logic             len_e,
  output logic             rd_valid,
  output logic [DataW-1:0] rd_data,
  output logic             rd_last,
  output logic [CntW-1:0]  pkt_cnt
);
  localparam int AW = $clog2(Depth);
  localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10;

  if (PktSzLsb + PktWidth > DataW) begin : g_bad_pkt_sz
    $error("pkt_sz field does not fit in the payload");
  end
  if ((Depth < 2) || ((1 << AW) != Depth)) begin : g_bad_depth
    $error("FIFO depth must be a power of 2, at least 2");
  end

  typedef struct packed {
    logic             last;
    logic [DataW-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t       state;
  entry_t       mem [Depth];
  logic [AW:0]  wptr, rptr;
  logic         full, empty, wr_type, wr_last, wr, rd_pop, dec;

`ifdef RAVENOC_PKT_LEN_CHECK_EN
  logic [PktWidth-1:0] remaining, pkt_sz;
  assign pkt_sz = payload[PktSzLsb +: PktWidth];
`endif

  // Extra pointer MSB tells full from empty when the low bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Classify the presented flit against the current framing state.
  always_comb begin
    wr_type = 1'b0;
    wr_last = 1'b0;
    seq_e   = 1'b0;
    len_e   = 1'b0;
    case (state)
      IDLE: begin
        if (ftype == HEAD) begin
          wr_type = 1'b1;
`ifdef RAVENOC_PKT_LEN_CHECK_EN
          wr_last = (pkt_sz == '0);
`endif
        end else begin
          seq_e = 1'b1;
        end
      end
      default: begin
        if (ftype == BODY) begin
          wr_type = 1'b1;
`ifdef RAVENOC_PKT_LEN_CHECK_EN
          len_e   = (remaining <= PktWidth'(1));
`endif
        end else if (ftype == TAIL) begin
          wr_type = 1'b1;
          wr_last = 1'b1;
`ifdef RAVENOC_PKT_LEN_CHECK_EN
          len_e   = (remaining != PktWidth'(1));
`endif
        end else begin
          seq_e = 1'b1;
        end
      end
    endcase
  end

  // Dropped flits are always taken; ready never looks at a same-cycle pop.
  assign ready  = ~wr_type | ~full;
  assign wr     = acc & wr_type;
  assign rd_pop = pop & ~empty;
  assign dec    = rd_pop & mem[rptr[AW-1:0]].last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef RAVENOC_PKT_LEN_CHECK_EN
      remaining <= '0;
`endif
    end else if (acc) begin
      case (state)
        IDLE: begin
          if (ftype == HEAD) begin
`ifdef RAVENOC_PKT_LEN_CHECK_EN
            if (pkt_sz != '0) begin
              state     <= IN_PKT;
              remaining <= pkt_sz;
            end
`else
            state <= IN_PKT;
`endif
          end
        end
        default: begin
          if (ftype == BODY) begin
`ifdef RAVENOC_PKT_LEN_CHECK_EN
            if (remaining != '0) remaining <= remaining - PktWidth'(1);
`endif
          end else if (ftype == TAIL) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      pkt_cnt <= '0;
    end else begin
      if (wr)     wptr <= wptr + (AW+1)'(1);
      if (rd_pop) rptr <= rptr + (AW+1)'(1);
      case ({wr & wr_last, dec})
        2'b10:   pkt_cnt <= pkt_cnt + CntW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CntW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by empty.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= '{last: wr_last, data: payload};
  end

  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rptr[AW-1:0]].data;
  assign rd_last  = ~empty & mem[rptr[AW-1:0]].last;
endmodule

module pkt_reasm #(
  parameter int FlitWidth     = 34,
  parameter int FlitDataWidth = 32,
  parameter int NumVC         = 3,
  parameter int FifoDepth     = 4,
  parameter int PktWidth      = 8,
  parameter int PktSzLsb      = 16,
  localparam int VcW          = $clog2(NumVC),
  localparam int CntW         = $clog2(FifoDepth + 1)
) (
  input  logic                     clk_noc,
  input  logic                     arst_noc,
  input  logic                     flit_valid_i,
  input  logic [FlitWidth-1:0]     flit_data_i,
  input  logic [VcW-1:0]           flit_vc_i,
  output logic                     flit_ready_o,
  input  logic [VcW-1:0]           rd_vc_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [FlitDataWidth-1:0] rd_data_o,
  output logic                     rd_last_o,
  output logic [NumVC*CntW-1:0]    pkt_avail_o,
  output logic                     seq_err_o,
  output logic                     len_err_o,
  output logic [VcW-1:0]           err_vc_o
);
  logic [1:0]                            ftype;
  logic [NumVC-1:0]                      acc, pop, rdy, seq_e, len_e, vld, last;
  logic [NumVC-1:0][FlitDataWidth-1:0]   data;
  logic [NumVC-1:0][CntW-1:0]            cnt;

  assign ftype = flit_data_i[FlitWidth-1 -: 2];

  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    assign acc[v] = flit_valid_i & flit_ready_o & (flit_vc_i == VcW'(v));
    assign pop[v] = rd_ready_i & (rd_vc_i == VcW'(v));

    pkt_reasm_vc #(
      .DataW(FlitDataWidth), .Depth(FifoDepth),
      .PktWidth(PktWidth), .PktSzLsb(PktSzLsb)
    ) u_vc (
      .clk(clk_noc), .rst_n(arst_noc),
      .acc(acc[v]), .ftype(ftype), .payload(flit_data_i[FlitDataWidth-1:0]),
      .pop(pop[v]), .ready(rdy[v]), .seq_e(seq_e[v]), .len_e(len_e[v]),
      .rd_valid(vld[v]), .rd_data(data[v]), .rd_last(last[v]),
      .pkt_cnt(cnt[v])
    );
  end

  assign pkt_avail_o = cnt;

  // VC select muxes; an out-of-range VC takes (and drops) flits and reads empty.
  always_comb begin
    flit_ready_o = 1'b1;
    rd_valid_o   = 1'b0;
    rd_data_o    = '0;
    rd_last_o    = 1'b0;
    for (int v = 0; v < NumVC; v++) begin
      if (flit_vc_i == VcW'(v)) flit_ready_o = rdy[v];
      if (rd_vc_i == VcW'(v)) begin
        rd_valid_o = vld[v];
        rd_data_o  = data[v];
        rd_last_o  = last[v];
      end
    end
  end

  // Only one flit per cycle, so at most one VC flags an error.
  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) begin
      seq_err_o <= 1'b0;
      len_err_o <= 1'b0;
      err_vc_o  <= '0;
    end else begin
      seq_err_o <= |(acc & seq_e);
      len_err_o <= |(acc & len_e);
      if (|(acc & (seq_e | len_e))) err_vc_o <= flit_vc_i;
    end
  end
endmodule

// File: tb/tb_pkt_reasm.sv
module tb_pkt_reasm;
  localparam int FW = 34, DW = 32, NV = 3, FD = 4, PW = 8, PL = 16, VW = 2, CW = 3;
`ifdef RAVENOC_PKT_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif
  localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, BAD = 2'b11;

  logic          clk_noc = 1'b0, arst_noc;
  logic          flit_valid_i, flit_ready_o, rd_ready_i, rd_valid_o, rd_last_o;
  logic [FW-1:0] flit_data_i;
  logic [VW-1:0] flit_vc_i, rd_vc_i, err_vc_o;
  logic [DW-1:0] rd_data_o;
  logic [NV*CW-1:0] pkt_avail_o;
  logic          seq_err_o, len_err_o;

  always #5 clk_noc = ~clk_noc;

  pkt_reasm dut (
    .clk_noc(clk_noc), .arst_noc(arst_noc),
    .flit_valid_i(flit_valid_i), .flit_data_i(flit_data_i), .flit_vc_i(flit_vc_i),
    .flit_ready_o(flit_ready_o), .rd_vc_i(rd_vc_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .pkt_avail_o(pkt_avail_o), .seq_err_o(seq_err_o), .len_err_o(len_err_o),
    .err_vc_o(err_vc_o)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue of {last, data} per VC plus framing state.
  logic [32:0] mq [NV][$];
  bit          in_pkt [NV];
  int          rem [NV];
  bit          e_seq, e_len;
  logic [1:0]  e_vc;

  function automatic int avail(int v);
    int n = 0;
    foreach (mq[v][i]) if (mq[v][i][32]) n++;
    return n;
  endfunction

  function automatic void classify(int v, logic [1:0] ty, logic [31:0] d,
                                   output bit wr, output bit last,
                                   output bit seq, output bit len);
    logic [PW-1:0] psz = d[PL +: PW];
    wr = 0; last = 0; seq = 0; len = 0;
    if (!in_pkt[v]) begin
      if (ty == HD) begin wr = 1; last = LEN_EN && (psz == 0); end
      else seq = 1;
    end else if (ty == BD) begin
      wr = 1; len = LEN_EN && (rem[v] <= 1);
    end else if (ty == TL) begin
      wr = 1; last = 1; len = LEN_EN && (rem[v] != 1);
    end else seq = 1;
  endfunction

  function automatic void model_clear();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete(); in_pkt[v] = 0; rem[v] = 0;
    end
    e_seq = 0; e_len = 0; e_vc = '0;
  endfunction

  // One clock: check all outputs at the negedge, then advance the model.
  task automatic step();
    bit wr, last, seq, len, rdy, acc, pop;
    int v, rv;
    logic [1:0] ty;
    logic [31:0] d;
    @(negedge clk_noc);
    v = int'(flit_vc_i); rv = int'(rd_vc_i);
    ty = flit_data_i[33:32]; d = flit_data_i[31:0];
    classify(v, ty, d, wr, last, seq, len);
    rdy = !wr || (mq[v].size() < FD);
    chk("flit_ready", flit_ready_o, rdy);
    chk("rd_valid", rd_valid_o, mq[rv].size() != 0);
    if (mq[rv].size() != 0) begin
      chk("rd_data", rd_data_o, mq[rv][0][31:0]);
      chk("rd_last", rd_last_o, mq[rv][0][32]);
    end
    for (int w = 0; w < NV; w++)
      chk($sformatf("pkt_avail%0d", w), pkt_avail_o[w*CW +: CW], avail(w));
    chk("seq_err", seq_err_o, e_seq);
    chk("len_err", len_err_o, e_len);
    chk("err_vc", err_vc_o, e_vc);
    acc = flit_valid_i && rdy;
    pop = rd_ready_i && (mq[rv].size() != 0);
    @(posedge clk_noc);
    e_seq = acc && seq;
    e_len = acc && len;
    if (e_seq || e_len) e_vc = 2'(v);
    if (pop) void'(mq[rv].pop_front());
    if (acc && wr) begin
      mq[v].push_back({last, d});
      if (ty == HD) begin
        in_pkt[v] = LEN_EN ? (d[PL +: PW] != 0) : 1'b1;
        rem[v] = int'(d[PL +: PW]);
      end else if (ty == BD) begin
        if (rem[v] > 0) rem[v]--;
      end else in_pkt[v] = 0;
    end
    #1;
  endtask

  task automatic fl(int v, logic [1:0] ty, logic [31:0] d);
    flit_valid_i = 1; flit_vc_i = 2'(v); flit_data_i = {ty, d}; rd_ready_i = 0;
    step();
    flit_valid_i = 0;
  endtask

  task automatic rd(int v, int n);
    flit_valid_i = 0; rd_vc_i = 2'(v); rd_ready_i = 1;
    repeat (n) step();
    rd_ready_i = 0;
  endtask

  task automatic rst_pulse();
    flit_valid_i = 0; rd_ready_i = 0; arst_noc = 0;
    model_clear();
    @(posedge clk_noc); #1;
    arst_noc = 1;
  endtask

  function automatic logic [31:0] hd(int sz);
    return 32'(sz & 8'hff) << PL;
  endfunction

  initial begin
    flit_valid_i = 0; flit_data_i = '0; flit_vc_i = '0; rd_vc_i = '0; rd_ready_i = 0;
    arst_noc = 0;
    model_clear();
    #2;
    rst_pulse();
    chk("rst_data", rd_data_o, 0);
    chk("rst_last", rd_last_o, 0);
    chk("rst_avail", pkt_avail_o, 0);
    step();

    // 1: three-flit packet on VC1, then drain
    fl(1, HD, 32'h0002_0000);
    fl(1, BD, 32'hA5A5_A5A5);
    fl(1, TL, 32'h1234_5678);
    chk("t1_avail", pkt_avail_o[CW +: CW], 1);
    rd(1, 3);
    chk("t1_drain", pkt_avail_o[CW +: CW], 0);
    step();

    // 2: fill VC0, blocked flit, then pop frees space one cycle later
    if (LEN_EN) begin
      repeat (4) fl(0, HD, hd(0));
    end else begin
      fl(0, HD, hd(0));
      repeat (3) fl(0, BD, 32'h0);
    end
    chk("t2_full_ready", flit_ready_o, 0);
    fl(0, LEN_EN ? HD : BD, 32'h55);
    flit_valid_i = 1; rd_vc_i = 0; rd_ready_i = 1;
    step();
    rd_ready_i = 0;
    step();
    flit_valid_i = 0;
    if (!LEN_EN) fl(0, TL, 32'h77);
    rd(0, 6);

    // 3: BODY on idle VC2 is dropped with a framing error
    fl(2, BD, 32'hDEAD_BEEF);
    chk("t3_seq", seq_err_o, 1);
    chk("t3_vc", err_vc_o, 2);
    rd_vc_i = 2;
    step();
    chk("t3_empty", rd_valid_o, 0);

    // 4: short packet on VC0
    fl(0, HD, hd(3));
    fl(0, BD, 32'h1);
    fl(0, TL, 32'h2);
    chk("t4_len", len_err_o, LEN_EN);
    chk("t4_avail", pkt_avail_o[0 +: CW], 1);
    step();
    rd(0, 3);

    // 5: interleaved VC0/VC1, then pops on VC1 alongside VC0 writes
    fl(0, HD, hd(1));
    fl(1, HD, hd(1));
    fl(1, TL, 32'hB1);
    fl(0, TL, 32'hA0);
    chk("t5_avail0", pkt_avail_o[0 +: CW], 1);
    chk("t5_avail1", pkt_avail_o[CW +: CW], 1);
    flit_valid_i = 1; flit_vc_i = 0; rd_vc_i = 1; rd_ready_i = 1;
    flit_data_i = {HD, hd(0)};
    step();
    flit_data_i = {LEN_EN ? HD : BD, hd(0)};
    step();
    flit_valid_i = 0; rd_ready_i = 0;
    step();
    rd(0, 5);
    if (!LEN_EN) begin fl(0, TL, 32'h0); rd(0, 2); end

    // 6: reset during a VC1 packet
    fl(1, HD, hd(2));
    rst_pulse();
    chk("t6_avail", pkt_avail_o, 0);
    rd_vc_i = 1;
    step();
    fl(1, TL, 32'h9);
    chk("t6_seq", seq_err_o, 1);
    step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r = int'($urandom_range(0, 99));
      logic [1:0] ty = (r < 30) ? HD : (r < 65) ? BD : (r < 90) ? TL : BAD;
      flit_valid_i = ($urandom_range(0, 9) < 8);
      flit_vc_i    = 2'($urandom_range(0, NV - 1));
      flit_data_i  = {ty, $urandom() & 32'hFF00_FFFF | hd(int'($urandom_range(0, 3)))};
      rd_vc_i      = 2'($urandom_range(0, NV - 1));
      rd_ready_i   = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 999) == 0) rst_pulse();
      else step();
    end
    flit_valid_i = 0; rd_ready_i = 0;
    step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/pkt_reasm.md
Name: pkt_reasm

Overview:
- Receive-side flit decoder and packet reassembler between the router local output port and the AXI RX read path.
- Accepts typed flits (head/body/tail) per virtual channel and tracks each VC's framing with a small FSM.
- Strips the flit type and buffers payload per VC with an end-of-packet marker.
- Exposes a per-VC count of complete packets, and flags framing and length errors.

Parameters:
- FlitWidth, 34, total flit width: 2-bit type in [FlitWidth-1:FlitWidth-2] plus payload.
- FlitDataWidth, 32, payload width.
- NumVC, 3, number of virtual channels.
- FifoDepth, 4, entries per VC buffer; power of 2, ≥2.
- PktWidth, 8, width of the packet-size field in the head flit.
- PktSzLsb, 16, LSB position of the pkt_sz field inside the head payload.

Ports:
- clk_noc  in  1  NoC clock.
- arst_noc  in  1  asynchronous reset, active-low.
- flit_valid_i  in  1  incoming flit valid.
- flit_data_i  in  FlitWidth  incoming flit (type + payload).
- flit_vc_i  in  $clog2(NumVC)  VC of incoming flit.
- flit_ready_o  out  1  flit accepted when valid&ready.
- rd_vc_i  in  $clog2(NumVC)  VC selected for reading.
- rd_ready_i  in  1  consumer pops selected VC head entry.
- rd_valid_o  out  1  selected VC buffer non-empty.
- rd_data_o  out  FlitDataWidth  head entry payload of selected VC.
- rd_last_o  out  1  head entry is last flit of its packet.
- pkt_avail_o  out  NumVC*$clog2(FifoDepth+1)  per-VC count of complete packets buffered.
- seq_err_o  out  1  one-cycle pulse, framing error.
- len_err_o  out  1  one-cycle pulse, length mismatch.
- err_vc_o  out  $clog2(NumVC)  VC of the latest error, held until next error.

Behaviour:
- Flit type encoding: HEAD=2'b00, BODY=2'b01, TAIL=2'b10, 2'b11 = framing error.
- Reset values: all FIFOs empty, all FSMs IDLE, all counters 0.
  - Outputs at reset: rd_valid_o=0, rd_data_o=0, rd_last_o=0, pkt_avail_o=0, seq_err_o=0, len_err_o=0, err_vc_o=0.
- Per-VC FSM, two states:
  - IDLE:
    - HEAD with pkt_sz=0: written with last=1, stay IDLE.
    - HEAD with pkt_sz>0: written with last=0, remaining:=pkt_sz, go IN_PKT.
    - BODY, TAIL or 2'b11: dropped (not written), seq_err_o pulse, stay IDLE.
  - IN_PKT:
    - BODY: written with last=0, remaining-1, saturating at 0.
    - TAIL: written with last=1, go IDLE.
    - HEAD or 2'b11: dropped, seq_err_o pulse, stay IN_PKT.
- Length check:
  - TAIL with remaining≠1 → len_err_o pulse; still written and closes the packet.
  - BODY with remaining≤1 → len_err_o pulse; still written.
- flit_ready_o:
  - Flit to be written: ready = ~full[flit_vc_i].
  - Flit to be dropped: ready=1 regardless of full.
  - Combinational from flit_vc_i/type; no dependency on flit_valid_i.
- FSM state and counters update only on flit_valid_i & flit_ready_o.
- Latency: flit accepted at edge N is visible on rd_* after edge N (registered write, combinational read of selected VC).
- rd_* reflect the FIFO head of VC rd_vc_i. A pop occurs on rd_valid_o & rd_ready_i; rd_ready_i with an empty VC is ignored.
- pkt_avail[v]:
  - +1 when an entry with last=1 is written to v.
  - −1 when an entry with last=1 is popped from v.
  - Simultaneous +1/−1 leaves it unchanged.
  - Never exceeds FifoDepth.
- Simultaneous write and pop on the same VC, both allowed:
  - When full: the pop frees space next cycle; ready does not rely on same-cycle pop.
  - When empty: the written entry is not bypassed to rd_* in the same cycle.
- FIFO pointers wrap modulo FifoDepth using an extra MSB for the full/empty distinction.
- Errors on multiple VCs cannot occur in the same cycle (one flit per cycle). err_vc_o updates only on an error pulse.
- Reset mid-operation: partial packets discarded, FSMs to IDLE, buffered data lost. No error is raised after reset.

Optional Feature:
- Macro RAVENOC_PKT_LEN_CHECK_EN.
- Defined: pkt_sz extracted from head payload [PktSzLsb+PktWidth-1:PktSzLsb]; remaining counter and len_err_o behave as above.
- Undefined:
  - No remaining counter; framing by flit type only.
  - HEAD in IDLE always goes IN_PKT with last=0 (no single-flit packets).
  - len_err_o tied 0.
  - seq_err_o unchanged.

Test Plan:
1. VC1: HEAD(pkt_sz=2, payload 0x0002_0000), BODY 0xA5A5_A5A5, TAIL 0x1234_5678, rd_ready_i=0 → pkt_avail[1]=1 after tail. Then rd_vc_i=1, rd_ready_i=1 → pops 0x00020000/0, 0xA5A5A5A5/0, 0x12345678/1; pkt_avail[1]=0; no errors.
2. VC0: 4 BODY-less HEADs, pkt_sz=0, FifoDepth=4 → pkt_avail[0]=4, flit_ready_o=0 for a 5th VC0 head. Pop one → ready=1 next cycle.
3. VC2: BODY while IDLE → accepted (ready=1), not buffered, seq_err_o=1 for one cycle, err_vc_o=2, rd_valid_o=0 for VC2.
4. VC0: HEAD pkt_sz=3, BODY, TAIL → tail buffered last=1, len_err_o pulse, err_vc_o=0, pkt_avail[0]=1. Macro undefined → no len_err_o.
5. Interleave VC0 HEAD(pkt_sz=1), VC1 HEAD(pkt_sz=1), VC1 TAIL, VC0 TAIL → independent framing, pkt_avail[0]=pkt_avail[1]=1. Same-cycle pop on VC1 with VC0 write → both counts correct.
6. arst_noc low for 1 cycle after VC1 HEAD → pkt_avail_o=0, rd_valid_o=0. Subsequent VC1 TAIL → seq_err_o pulse (FSM back in IDLE).
